// File: rtl/ppu_vram_arbiter_pkg.sv
// ppu_vram_arbiter_pkg: shared widths and arbiter state encoding for the PPU VRAM arbiter
package ppu_vram_arbiter_pkg;
  localparam int PPU_ADDR_W = 14;
  localparam int PPU_DATA_W = 8;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_ISSUE = 2'd1, ARB_CAPTURE = 2'd2} arb_state_e;
endpackage

// File: rtl/ppu_vram_arbiter_if.sv
// ppu_vram_arbiter_if: render, CPU ($2007) and memory bus signals of the PPU VRAM arbiter
interface ppu_vram_arbiter_if;
  import ppu_vram_arbiter_pkg::*;
  logic rend_en, rend_req, rend_ack, rend_valid;
  logic [PPU_ADDR_W-1:0] rend_addr, cpu_addr, mem_addr;
  logic [PPU_DATA_W-1:0] rend_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic cpu_wr_req, cpu_rd_req, cpu_busy, cpu_done, mem_rd, mem_wr;
  modport master(
    output rend_en, rend_req, rend_addr, cpu_wr_req, cpu_rd_req, cpu_addr, cpu_wdata, mem_rdata,
    input rend_ack, rend_valid, rend_data, cpu_busy, cpu_done, cpu_rdata, mem_addr, mem_wdata, mem_rd, mem_wr
  );
  modport slave(
    input rend_en, rend_req, rend_addr, cpu_wr_req, cpu_rd_req, cpu_addr, cpu_wdata, mem_rdata,
    output rend_ack, rend_valid, rend_data, cpu_busy, cpu_done, cpu_rdata, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/ppu_cpu_port_buf.sv
// ppu_cpu_port_buf: single-entry $2007 request holder with busy flag and delayed read buffer
module ppu_cpu_port_buf import ppu_vram_arbiter_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic [PPU_ADDR_W-1:0] addr,
  input  logic [PPU_DATA_W-1:0] wdata,
  input  logic                  done,
  input  logic                  load,
  input  logic [PPU_DATA_W-1:0] load_data,
  output logic                  busy,
  output logic                  pend_wr,
  output logic [PPU_ADDR_W-1:0] pend_addr,
  output logic [PPU_DATA_W-1:0] pend_wdata,
  output logic [PPU_DATA_W-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
      pend_wr <= 1'b0;
      pend_addr <= '0;
      pend_wdata <= '0;
      rdata <= '0;
    end else begin
      // a write wins over a simultaneous read; anything arriving while busy is dropped
      if (!busy && (wr_req || rd_req)) begin
        busy <= 1'b1;
        pend_wr <= wr_req;
        pend_addr <= addr;
        pend_wdata <= wdata;
      end else if (done) busy <= 1'b0;
      if (load) rdata <= load_data;
    end
  end
endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: render-priority PPU VRAM arbiter with $2007 port; PPU_ARB_STARVE_GUARD_EN adds CPU starvation guard
module ppu_vram_arbiter import ppu_vram_arbiter_pkg::*; #(
  parameter int MAX_CPU_WAIT = 16
) (
  input logic clk,
  input logic rst,
  ppu_vram_arbiter_if.slave bus
);
  arb_state_e state, state_n;
  logic op_cpu, op_wr, force_cpu, grant_rend, grant_cpu;
  logic busy, pend_wr;
  logic [PPU_ADDR_W-1:0] pend_addr;
  logic [PPU_DATA_W-1:0] pend_wdata;
  ppu_cpu_port_buf u_cpu (
    .clk(clk), .rst(rst), .wr_req(bus.cpu_wr_req), .rd_req(bus.cpu_rd_req),
    .addr(bus.cpu_addr), .wdata(bus.cpu_wdata), .done(bus.cpu_done),
    .load(state == ARB_CAPTURE && op_cpu), .load_data(bus.mem_rdata),
    .busy(busy), .pend_wr(pend_wr), .pend_addr(pend_addr), .pend_wdata(pend_wdata),
    .rdata(bus.cpu_rdata)
  );
  assign bus.cpu_busy = busy;
`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  assign force_cpu = busy && wait_cnt == WAIT_W'(MAX_CPU_WAIT);
  always_ff @(posedge clk) begin
    if (!rst) wait_cnt <= '0;
    else if (grant_cpu) wait_cnt <= '0;
    else if (busy && grant_rend) wait_cnt <= wait_cnt + WAIT_W'(1);
  end
`else
  assign force_cpu = 1'b0;
`endif
  always_comb begin
    grant_rend = state == ARB_IDLE && bus.rend_en && bus.rend_req && !force_cpu;
    grant_cpu = state == ARB_IDLE && busy && !grant_rend;
    state_n = state == ARB_IDLE ? ((grant_rend || grant_cpu) ? ARB_ISSUE : ARB_IDLE) :
              state == ARB_ISSUE ? (op_wr ? ARB_IDLE : ARB_CAPTURE) : ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= ARB_IDLE;
    else state <= state_n;
  end
  assign bus.rend_ack = rst && grant_rend;
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_cpu <= 1'b0;
      op_wr <= 1'b0;
      bus.mem_rd <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_done <= 1'b0;
      bus.rend_valid <= 1'b0;
      bus.rend_data <= '0;
    end else begin
      bus.mem_rd <= grant_rend || (grant_cpu && !pend_wr);
      bus.mem_wr <= grant_cpu && pend_wr;
      bus.cpu_done <= (grant_cpu && pend_wr) || (state == ARB_ISSUE && op_cpu && !op_wr);
      bus.rend_valid <= state == ARB_CAPTURE && !op_cpu;
      if (state == ARB_CAPTURE && !op_cpu) bus.rend_data <= bus.mem_rdata;
      if (grant_rend || grant_cpu) begin
        op_cpu <= grant_cpu;
        op_wr <= grant_cpu && pend_wr;
        bus.mem_addr <= grant_cpu ? pend_addr : bus.rend_addr;
      end
      if (grant_cpu && pend_wr) bus.mem_wdata <= pend_wdata;
    end
  end
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: scoreboard bench with memory model, directed cases and random traffic
module tb_ppu_vram_arbiter;
  typedef struct {logic [13:0] a; logic [7:0] d; int c;} rexp_t;
  typedef struct {bit wr; logic [13:0] a; logic [7:0] d;} cexp_t;
  logic clk = 0, rst = 0;
  int cyc = 0, checks = 0, failures = 0;
  logic [7:0] mem [0:16383];
  logic [7:0] shadow [0:16383];
  rexp_t rq[$];
  cexp_t cq[$];
  rexp_t re;
  cexp_t ce;
  bit model_busy, acc_now, ack_seen, rd_pend, memrd_pend, rst_low_prev;
  logic [7:0] model_buf, rd_val;
  logic [13:0] memrd_addr;
  int acks, denied, dones, rd_cnt, wr_cnt, last_done;
  ppu_vram_arbiter_if bus();
  ppu_vram_arbiter #(.MAX_CPU_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end
  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'(a >> 6) ^ 8'h3C;
  endfunction
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (rst_low_prev)
        chk({bus.rend_ack, bus.rend_valid, bus.rend_data, bus.cpu_busy, bus.cpu_done, bus.cpu_rdata,
             bus.mem_addr, bus.mem_wdata, bus.mem_rd, bus.mem_wr} == 44'd0, "reset_outputs",
            {bus.rend_ack, bus.rend_valid, bus.cpu_busy, bus.cpu_done, bus.mem_rd, bus.mem_wr, bus.cpu_rdata, bus.rend_data}, 0);
      rq.delete();
      cq.delete();
      model_busy = 0; model_buf = 0; rd_pend = 0; memrd_pend = 0; acc_now = 0;
      rst_low_prev = 1;
    end else begin
      rst_low_prev = 0;
      chk(bus.cpu_busy == model_busy, "cpu_busy", bus.cpu_busy, model_busy);
      if (memrd_pend) begin
        chk(bus.mem_rd && bus.mem_addr == memrd_addr, "render_mem_rd", {bus.mem_rd, bus.mem_addr}, {1'b1, memrd_addr});
        memrd_pend = 0;
      end
      if (rd_pend) begin
        chk(bus.cpu_rdata == rd_val, "read_buffer", bus.cpu_rdata, rd_val);
        rd_pend = 0;
      end
      if (bus.rend_ack) begin
        chk(bus.rend_en && bus.rend_req, "ack_qualified", {bus.rend_en, bus.rend_req}, 2'b11);
        rq.push_back('{bus.rend_addr, shadow[bus.rend_addr], cyc + 3});
        memrd_pend = 1; memrd_addr = bus.rend_addr; ack_seen = 1; acks++;
        if (model_busy) denied++;
      end
      if (bus.rend_valid) begin
        if (rq.size() == 0) chk(0, "rend_valid_unexpected", bus.rend_data, 0);
        else begin
          re = rq.pop_front();
          chk(bus.rend_data == re.d && cyc == re.c, "rend_data", {bus.rend_data, 24'(cyc)}, {re.d, 24'(re.c)});
        end
      end
      if (bus.cpu_done) begin
        dones++; last_done = cyc;
        chk(!bus.rend_ack, "done_ack_exclusive", bus.rend_ack, 0);
        if (cq.size() == 0) chk(0, "cpu_done_unexpected", bus.mem_addr, 0);
        else begin
          ce = cq.pop_front();
          if (ce.wr) chk(bus.mem_wr && bus.mem_addr == ce.a && bus.mem_wdata == ce.d, "cpu_write",
                         {bus.mem_wr, bus.mem_addr, bus.mem_wdata}, {1'b1, ce.a, ce.d});
          else begin rd_pend = 1; rd_val = ce.d; end
        end
      end
      if (bus.mem_rd) rd_cnt++;
      if (bus.mem_wr) wr_cnt++;
      if (bus.cpu_done) model_busy = 0;
      if (acc_now) begin model_busy = 1; acc_now = 0; end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_issue(input bit wr, input bit rd, input logic [13:0] a, input logic [7:0] d);
    bus.cpu_wr_req = wr; bus.cpu_rd_req = rd; bus.cpu_addr = a; bus.cpu_wdata = d;
    if (!model_busy && (wr || rd)) begin
      acc_now = 1;
      if (wr) begin
        shadow[a] = d;
        cq.push_back('{1'b1, a, d});
      end else begin
        chk(bus.cpu_rdata == model_buf, "delayed_read", bus.cpu_rdata, model_buf);
        model_buf = shadow[a];
        cq.push_back('{1'b0, a, model_buf});
      end
    end
  endtask
  task automatic cpu_clear();
    bus.cpu_wr_req = 0; bus.cpu_rd_req = 0;
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while (model_busy && n < bound) begin step(); n++; end
    if (model_busy) chk(0, "wait_timeout", n, bound);
  endtask
  initial begin
    int d0, a0, k, r0, w0;
    for (int i = 0; i < 16384; i++) begin mem[i] = init_val(i); shadow[i] = init_val(i); end
    mem[14'h2000] = 8'h5A; shadow[14'h2000] = 8'h5A;
    bus.rend_en = 0; bus.rend_req = 0; bus.rend_addr = 0; bus.mem_rdata = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0; cpu_clear();
    repeat (3) step();
    rst = 1;
    step();
    bus.rend_en = 1; bus.rend_req = 1; bus.rend_addr = 14'h0010; ack_seen = 0;
    step();
    chk(ack_seen, "pre_reset_ack", ack_seen, 1);
    bus.rend_req = 0;
    step();
    rst = 0;
    repeat (2) step();
    rst = 1;
    step();
    ack_seen = 0; bus.rend_req = 1; bus.rend_addr = 14'h2000;
    step();
    chk(ack_seen, "idle_after_reset_ack", ack_seen, 1);
    bus.rend_req = 0;
    repeat (4) step();
    chk(rq.size() == 0, "render_drained", rq.size(), 0);
    d0 = dones;
    cpu_issue(1, 0, 14'h2400, 8'hA5); step(); cpu_clear(); wait_idle(10); step();
    cpu_issue(0, 1, 14'h2400, 0); step(); cpu_clear(); wait_idle(10); step();
    cpu_issue(0, 1, 14'h2400, 0);
    chk(bus.cpu_rdata == 8'hA5, "second_read_value", bus.cpu_rdata, 8'hA5);
    step(); cpu_clear(); wait_idle(10); step();
    chk(dones - d0 == 3, "one_done_per_access", dones - d0, 3);
    r0 = rd_cnt; w0 = wr_cnt; d0 = dones;
    cpu_issue(1, 1, 14'h2401, 8'h3C); step(); cpu_clear();
    cpu_issue(0, 1, 14'h2402, 0); step(); cpu_clear();
    wait_idle(10); repeat (3) step();
    chk(wr_cnt - w0 == 1 && rd_cnt - r0 == 0, "write_wins", {16'(wr_cnt - w0), 16'(rd_cnt - r0)}, {16'd1, 16'd0});
    chk(dones - d0 == 1, "busy_request_dropped", dones - d0, 1);
    d0 = dones; a0 = denied;
    bus.rend_en = 1; bus.rend_req = 1; bus.rend_addr = 14'h0100;
    cpu_issue(0, 1, 14'h2800, 0); step(); cpu_clear();
`ifdef PPU_ARB_STARVE_GUARD_EN
    wait_idle(60);
    chk(denied - a0 == 4, "guard_denials", denied - a0, 4);
    bus.rend_req = 0;
`else
    repeat (60) step();
    chk(dones - d0 == 0 && model_busy, "starved_cpu", {16'(dones - d0), 15'd0, model_busy}, 32'd1);
    chk(denied - a0 >= 15, "starve_denials", denied - a0, 15);
    bus.rend_req = 0;
    wait_idle(10);
`endif
    repeat (4) step();
    a0 = acks;
    bus.rend_en = 0; bus.rend_req = 1; bus.rend_addr = 14'h0200;
    cpu_issue(0, 1, 14'h2C00, 0); k = cyc; step(); cpu_clear();
    wait_idle(10);
    chk(last_done == k + 3, "rend_en_off_cpu_latency", last_done, k + 3);
    chk(acks == a0, "rend_en_off_no_ack", acks - a0, 0);
    bus.rend_req = 0; bus.rend_en = 1; ack_seen = 0;
    step();
    for (int i = 0; i < 1500; i++) begin
      if (!bus.rend_req || ack_seen) begin
        bus.rend_req = 1'($urandom_range(0, 1));
        bus.rend_addr = 14'($urandom_range(0, 14'h1FFF));
        ack_seen = 0;
      end
      bus.rend_en = $urandom_range(0, 15) != 0;
      k = $urandom_range(0, 7);
      cpu_issue(k == 0 || k == 2, k == 1 || k == 2, 14'h2000 | 14'($urandom_range(0, 15)), 8'($urandom));
      step();
      cpu_clear();
    end
    bus.rend_req = 0;
    wait_idle(20);
    repeat (6) step();
    chk(rq.size() == 0, "final_render_queue", rq.size(), 0);
    chk(cq.size() == 0, "final_cpu_queue", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
